// File: rtl/mem_arb_if.sv
// Requester-side bundle for mem_arb: two command ports with valid/ready
// handshake plus the tagged read-return path.
interface mem_arb_if #(
    parameter int MEM_SIZE  = 8,
    parameter int DATA_SIZE = 8
);
    logic                 req0, req1;
    logic                 we0, we1;
    logic [MEM_SIZE-1:0]  ad0, ad1;
    logic [1:0]           len0, len1;
    logic [DATA_SIZE-1:0] wd0, wd1;
    logic                 gnt0, gnt1;
    logic                 rvalid0, rvalid1;
    logic [DATA_SIZE-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, ad0, ad1, len0, len1, wd0, wd1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, ad0, ad1, len0, len1, wd0, wd1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );
endinterface

// File: rtl/mem_arb.sv
// Two-port round-robin arbiter and burst sequencer in front of a single-port
// memory with registered read. Commands are registered onto the memory port,
// burst addresses auto-increment, and read data comes back tagged per port.
module mem_arb #(
    parameter int MEM_SIZE  = 8,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_arb_if.slave             bus,
    output logic [MEM_SIZE-1:0]  mem_ad,
    output logic                 mem_we,
    output logic [DATA_SIZE-1:0] mem_wd,
    input  logic [DATA_SIZE-1:0] mem_rd
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_nxt;
    logic                 own, last, bwe;
    logic [1:0]           cnt;
    logic [MEM_SIZE-1:0]  addr;

    logic [1:0]           req;
    logic                 issue, first, port;
    logic [MEM_SIZE-1:0]  beat_ad;
    logic                 beat_we;
    logic [DATA_SIZE-1:0] beat_wd;
    logic [1:0]           beat_len;

    logic                 tv1, tp1, tv2, tp2;

    assign req = {bus.req1, bus.req0};

    // Arbitration, beat selection and next-state decode.
    always_comb begin
        issue     = 1'b0;
        first     = 1'b0;
        port      = own;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req[0] && req[1]) port = ~last;
                else                  port = req[1];
                issue = |req;
                first = issue;
            end
            BURST: begin
                port  = own;
                // Reads stream unconditionally; writes wait for fresh data.
                issue = bwe ? req[own] : 1'b1;
                if (issue && cnt == 2'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        beat_len = port ? bus.len1 : bus.len0;
        beat_ad  = first ? (port ? bus.ad1 : bus.ad0) : addr;
        beat_we  = first ? (port ? bus.we1 : bus.we0) : bwe;
        beat_wd  = port ? bus.wd1 : bus.wd0;
        if (first && beat_len != 2'd0) state_nxt = BURST;
    end

    assign bus.gnt0    = issue & ~port & rst;
    assign bus.gnt1    = issue &  port & rst;
    assign bus.rvalid0 = tv2 & ~tp2;
    assign bus.rvalid1 = tv2 &  tp2;
    assign bus.rdata   = mem_rd;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Burst bookkeeping and registered memory command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own    <= 1'b0;
            last   <= 1'b1;
            bwe    <= 1'b0;
            cnt    <= '0;
            addr   <= '0;
            mem_ad <= '0;
            mem_we <= 1'b0;
            mem_wd <= '0;
        end else begin
            mem_we <= issue & beat_we;
            if (issue) begin
                mem_ad <= beat_ad;
                mem_wd <= beat_wd;
                addr   <= beat_ad + MEM_SIZE'(1);
                if (first) begin
                    own  <= port;
                    last <= port;
                    bwe  <= beat_we;
                    cnt  <= beat_len;
                end else begin
                    cnt  <= cnt - 2'd1;
                end
            end
        end
    end

    // Two-stage read tag pipeline aligned with the memory's read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tv1 <= 1'b0;
            tp1 <= 1'b0;
            tv2 <= 1'b0;
            tp2 <= 1'b0;
        end else begin
            tv1 <= issue & ~beat_we;
            tp1 <= port;
            tv2 <= tv1;
            tp2 <= tp1;
        end
    end
endmodule
